// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the 3x3 RGB888 convolution engine.
package conv_pkg;

    localparam int unsigned N_TAPS  = 9;
    localparam int unsigned N_CHAN  = 3;
    localparam int unsigned CH_W    = 8;
    localparam int unsigned TAP_W   = 4;

    // Channel slice positions inside a packed RGB888 pixel: R, G, B.
    localparam int unsigned CH_LSB [N_CHAN] = '{16, 8, 0};

    // Identity kernel: centre tap at unity gain for SHIFT=4.
    localparam int unsigned ID_TAP  = 4;
    localparam int          ID_COEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/conv_chan_mac.sv
// One colour channel: unsigned pixel x signed coefficient accumulate, then
// round, shift, optional magnitude (CONV_ABS_EN) and saturate to 0..255.
module conv_chan_mac
    import conv_pkg::*;
#(
    parameter int unsigned COEF_W = 8,
    parameter int unsigned ACC_W  = 21,
    parameter int unsigned SHIFT  = 4
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iClear,
    input  logic                     iEn,
    input  logic [CH_W-1:0]          iPix,
    input  logic signed [COEF_W-1:0] iCoef,
    output logic [CH_W-1:0]          oResult
);

    localparam int unsigned PROD_W = CH_W + COEF_W + 1;
    localparam int unsigned RW     = ACC_W + 1;
    localparam logic signed [RW-1:0] ROUND = RW'((1 << SHIFT) >> 1);

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;
    logic signed [RW-1:0]     rounded;
    logic signed [RW-1:0]     shifted;
    logic signed [RW-1:0]     mag;

    assign prod = $signed({1'b0, iPix}) * iCoef;

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            acc <= '0;
        end else if (iClear) begin
            acc <= '0;
        end else if (iEn) begin
            acc <= acc + ACC_W'(prod);
        end
    end

    always_comb begin
        rounded = $signed({acc[ACC_W-1], acc}) + ROUND;
        shifted = rounded >>> SHIFT;
`ifdef CONV_ABS_EN
        mag = shifted[RW-1] ? -shifted : shifted;
`else
        mag = shifted;
`endif
        if (mag[RW-1]) begin
            oResult = '0;
        end else if (|mag[RW-2:CH_W]) begin
            oResult = '1;
        end else begin
            oResult = mag[CH_W-1:0];
        end
    end

endmodule

// File: rtl/conv3x3_mac.sv
// Sequential 3x3 RGB888 convolution: one tap per cycle, 11-cycle period.
// Define CONV_ABS_EN to output magnitudes instead of clamping negatives to 0.
module conv3x3_mac
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned COEF_W = 8,
    parameter int unsigned ACC_W  = 21,
    parameter int unsigned SHIFT  = 4
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iValid,
    input  logic [DATA_W-1:0]        iWin0,
    input  logic [DATA_W-1:0]        iWin1,
    input  logic [DATA_W-1:0]        iWin2,
    input  logic [DATA_W-1:0]        iWin3,
    input  logic [DATA_W-1:0]        iWin4,
    input  logic [DATA_W-1:0]        iWin5,
    input  logic [DATA_W-1:0]        iWin6,
    input  logic [DATA_W-1:0]        iWin7,
    input  logic [DATA_W-1:0]        iWin8,
    output logic                     oBusy,
    input  logic                     iCoefWe,
    input  logic [TAP_W-1:0]         iCoefAddr,
    input  logic signed [COEF_W-1:0] iCoefData,
    output logic [DATA_W-1:0]        oPixel,
    output logic                     oValid
);

    state_t                   state;
    logic [TAP_W-1:0]         tap;
    logic [DATA_W-1:0]        winIn   [N_TAPS];
    logic [DATA_W-1:0]        win     [N_TAPS];
    logic signed [COEF_W-1:0] coef    [N_TAPS];
    logic [DATA_W-1:0]        tapPix;
    logic signed [COEF_W-1:0] tapCoef;
    logic [CH_W-1:0]          chanRes [N_CHAN];
    logic [DATA_W-1:0]        outPix;
    logic                     capture;
    logic                     macEn;

    assign oBusy   = (state != IDLE);
    assign capture = (state == IDLE) && iValid;
    assign macEn   = (state == MAC);

    always_comb begin
        winIn[0] = iWin0;
        winIn[1] = iWin1;
        winIn[2] = iWin2;
        winIn[3] = iWin3;
        winIn[4] = iWin4;
        winIn[5] = iWin5;
        winIn[6] = iWin6;
        winIn[7] = iWin7;
        winIn[8] = iWin8;
    end

    always_comb begin
        tapPix  = '0;
        tapCoef = '0;
        for (int unsigned i = 0; i < N_TAPS; i++) begin
            if (tap == TAP_W'(i)) begin
                tapPix  = win[i];
                tapCoef = coef[i];
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            for (int unsigned i = 0; i < N_TAPS; i++) begin
                win[i] <= '0;
            end
        end else if (capture) begin
            for (int unsigned i = 0; i < N_TAPS; i++) begin
                win[i] <= winIn[i];
            end
        end
    end

    // Writes are gated on IDLE only, so a write on the capture edge still lands.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            for (int unsigned i = 0; i < N_TAPS; i++) begin
                coef[i] <= (i == ID_TAP) ? COEF_W'(ID_COEF) : '0;
            end
        end else if ((state == IDLE) && iCoefWe) begin
            for (int unsigned i = 0; i < N_TAPS; i++) begin
                if (iCoefAddr == TAP_W'(i)) begin
                    coef[i] <= iCoefData;
                end
            end
        end
    end

    for (genvar c = 0; c < N_CHAN; c++) begin : gChan
        conv_chan_mac #(
            .COEF_W (COEF_W),
            .ACC_W  (ACC_W),
            .SHIFT  (SHIFT)
        ) uChan (
            .iClk    (iClk),
            .iRst    (iRst),
            .iClear  (capture),
            .iEn     (macEn),
            .iPix    (tapPix[CH_LSB[c] +: CH_W]),
            .iCoef   (tapCoef),
            .oResult (chanRes[c])
        );
    end

    always_comb begin
        outPix = '0;
        for (int unsigned c = 0; c < N_CHAN; c++) begin
            outPix[CH_LSB[c] +: CH_W] = chanRes[c];
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state  <= IDLE;
            tap    <= '0;
            oValid <= 1'b0;
            oPixel <= '0;
        end else begin
            oValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (iValid) begin
                        state <= MAC;
                        tap   <= '0;
                    end
                end
                MAC: begin
                    if (tap == TAP_W'(N_TAPS - 1)) begin
                        state <= OUT;
                        tap   <= '0;
                    end else begin
                        tap <= tap + 1'b1;
                    end
                end
                OUT: begin
                    oPixel <= outPix;
                    oValid <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv3x3_mac.sv
// Scoreboard bench for conv3x3_mac: driver queues expected pixels, monitor checks.
module tb_conv3x3_mac;

    logic        iClk = 1'b0;
    logic        iRst = 1'b0;
    logic        iValid = 1'b0;
    logic        iCoefWe = 1'b0;
    logic [3:0]  iCoefAddr = 4'd0;
    logic [7:0]  iCoefData = 8'd0;
    logic [23:0] w [9];
    logic        oBusy;
    logic        oValid;
    logic [23:0] oPixel;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lastCap = 0;
    logic [23:0] expQ [$];
    int          capQ [$];

    conv3x3_mac dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iValid    (iValid),
        .iWin0     (w[0]),
        .iWin1     (w[1]),
        .iWin2     (w[2]),
        .iWin3     (w[3]),
        .iWin4     (w[4]),
        .iWin5     (w[5]),
        .iWin6     (w[6]),
        .iWin7     (w[7]),
        .iWin8     (w[8]),
        .oBusy     (oBusy),
        .iCoefWe   (iCoefWe),
        .iCoefAddr (iCoefAddr),
        .iCoefData (iCoefData),
        .oPixel    (oPixel),
        .oValid    (oValid)
    );

    always #5 iClk = ~iClk;
    always @(posedge iClk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: every result strobe must match the oldest queued expectation.
    always @(negedge iClk) begin
        logic [23:0] e;
        int          c;
        if (iRst && oValid) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ovalid got pixel %h expected no strobe", oPixel);
            end else begin
                e = expQ.pop_front();
                c = capQ.pop_front();
                check("pixel", oPixel, e);
                check("latency", 24'(cyc - c), 24'd10);
            end
        end
    end

    task automatic loadCoef(input logic [3:0] addr, input logic [7:0] data);
        @(negedge iClk);
        iCoefWe   = 1'b1;
        iCoefAddr = addr;
        iCoefData = data;
        @(posedge iClk);
        #1;
        iCoefWe = 1'b0;
    endtask

    task automatic sendWin(input string name, input logic [23:0] centre, input logic [23:0] others,
                           input logic [23:0] expPix, input bit push, input bit keep,
                           input bit spacing, input bit we, input logic [7:0] weData);
        int n;
        n = 0;
        while (oBusy && n < 50) begin
            @(negedge iClk);
            n++;
        end
        if (oBusy) check({name, "_idle_wait"}, 24'd1, 24'd0);
        for (int i = 0; i < 9; i++) w[i] = others;
        w[4] = centre;
        iValid = 1'b1;
        if (we) begin
            iCoefWe   = 1'b1;
            iCoefAddr = 4'd4;
            iCoefData = weData;
        end
        @(posedge iClk);
        #1;
        iCoefWe = 1'b0;
        check({name, "_capture"}, {23'd0, oBusy}, 24'd1);
        if (spacing) check({name, "_spacing"}, 24'(cyc - lastCap), 24'd11);
        lastCap = cyc;
        if (push) begin
            expQ.push_back(expPix);
            capQ.push_back(cyc);
        end
        if (!keep) iValid = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while ((expQ.size() != 0 || oBusy) && n < 60) begin
            @(negedge iClk);
            #1;
            n++;
        end
        check({name, "_drain"}, 24'(expQ.size()), 24'd0);
    endtask

    initial begin
        logic [23:0] absExp;
        for (int i = 0; i < 9; i++) w[i] = 24'h0;

        repeat (3) @(negedge iClk);
        check("reset_busy", {23'd0, oBusy}, 24'd0);
        check("reset_valid", {23'd0, oValid}, 24'd0);
        check("reset_pixel", oPixel, 24'h000000);
        iRst = 1'b1;

        // Identity kernel pass-through.
        sendWin("identity", 24'h123456, 24'hFFFFFF, 24'h123456, 1, 0, 0, 0, 8'd0);
        waitDrain("identity");

        // Out-of-range addresses are dropped.
        loadCoef(4'd9, 8'h7F);
        loadCoef(4'd15, 8'h40);
        sendWin("bad_addr", 24'h010203, 24'hFFFFFF, 24'h010203, 1, 0, 0, 0, 8'd0);
        waitDrain("bad_addr");

        // Coefficient write and iValid while busy are both ignored.
        sendWin("busy", 24'h204060, 24'h000000, 24'h204060, 1, 0, 0, 0, 8'd0);
        @(negedge iClk);
        iCoefWe = 1'b1; iCoefAddr = 4'd4; iCoefData = 8'd0; iValid = 1'b1;
        @(negedge iClk);
        iCoefWe = 1'b0; iValid = 1'b0;
        repeat (3) @(negedge iClk);
        iValid = 1'b1;
        @(negedge iClk);
        iValid = 1'b0;
        waitDrain("busy");
        repeat (3) @(negedge iClk);
        check("hold_pixel", oPixel, 24'h204060);
        sendWin("after_busy", 24'h0A0B0C, 24'h111111, 24'h0A0B0C, 1, 0, 0, 0, 8'd0);
        waitDrain("after_busy");

        // Laplacian kernel.
        for (int i = 0; i < 9; i++) loadCoef(4'(i), (i == 4) ? 8'd8 : 8'hFF);
        sendWin("lap_flat", 24'h808080, 24'h808080, 24'h000000, 1, 0, 0, 0, 8'd0);
`ifdef CONV_ABS_EN
        absExp = 24'h101010;
`else
        absExp = 24'h000000;
`endif
        sendWin("lap_neg", 24'h000000, 24'h202020, absExp, 1, 0, 0, 0, 8'd0);
        sendWin("lap_pos", 24'h202020, 24'h000000, 24'h101010, 1, 0, 0, 0, 8'd0);
        waitDrain("laplacian");

        // Centre 127: saturation and rounding.
        for (int i = 0; i < 9; i++) loadCoef(4'(i), (i == 4) ? 8'd127 : 8'd0);
        sendWin("sat", 24'hFF0001, 24'hFFFFFF, 24'hFF0008, 1, 0, 0, 0, 8'd0);
        waitDrain("sat");

        // Write on the capture edge applies to that window.
        sendWin("cap_write", 24'h101010, 24'hFFFFFF, 24'h202020, 1, 0, 0, 1, 8'd32);
        waitDrain("cap_write");

        // Reset mid-MAC discards the result and restores the identity kernel.
        sendWin("reset_mid", 24'h101010, 24'h000000, 24'h0, 0, 0, 0, 0, 8'd0);
        repeat (4) @(posedge iClk);
        #1;
        iRst = 1'b0;
        #1;
        check("midrst_busy", {23'd0, oBusy}, 24'd0);
        check("midrst_valid", {23'd0, oValid}, 24'd0);
        check("midrst_pixel", oPixel, 24'h000000);
        @(negedge iClk);
        @(negedge iClk);
        iRst = 1'b1;
        repeat (15) @(negedge iClk);
        sendWin("post_reset", 24'h123456, 24'hFFFFFF, 24'h123456, 1, 0, 0, 0, 8'd0);
        waitDrain("post_reset");

        // Back-to-back captures with iValid held high.
        sendWin("b2b_a", 24'h112233, 24'hFFFFFF, 24'h112233, 1, 1, 0, 0, 8'd0);
        sendWin("b2b_b", 24'h445566, 24'h0F0F0F, 24'h445566, 1, 1, 1, 0, 8'd0);
        sendWin("b2b_c", 24'h778899, 24'hF0F0F0, 24'h778899, 1, 0, 1, 0, 8'd0);
        waitDrain("b2b");

        repeat (5) @(negedge iClk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
